// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file: accepts up to SRC producer
// writes per cycle into an in-order circular queue, drains up to WRITE entries
// per cycle onto the regfile write ports, and offers a youngest-match bypass
// lookup over the queued entries.
module regfile_wb_queue #(
  parameter int DATA     = 32,
  parameter int ADDR     = 4,
  parameter int SRC      = 2,
  parameter int WRITE    = 1,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset_,
  input  logic [SRC-1:0]                    req_,
  input  logic [SRC-1:0][ADDR-1:0]          req_addr,
  input  logic [SRC-1:0][DATA-1:0]          req_data,
  output logic [SRC-1:0]                    ack,
  output logic [WRITE-1:0][ADDR-1:0]        waddr,
  output logic [WRITE-1:0]                  we_,
  output logic [WRITE-1:0][DATA-1:0]        wdata,
  input  logic [ADDR-1:0]                   qaddr,
  output logic                              qhit,
  output logic [DATA-1:0]                   qdata,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR-1:0]          e_addr [DEPTH];
  logic [DATA-1:0]          e_data [DEPTH];
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [CW-1:0]            free_slots;
  logic [CW-1:0]            pushes;
  logic [CW-1:0]            pops;
  logic [SRC-1:0]           push_en;
  logic [SRC-1:0][PW-1:0]   push_idx;
  logic [PW-1:0]            rd_idx;
  logic [PW-1:0]            lk_idx;

  // Free space is judged on the registered count only; this cycle's drain
  // is not credited, so acceptance never depends on the write ports.
  assign free_slots = CW'(DEPTH) - count;
  assign pops       = (count < CW'(WRITE)) ? count : CW'(WRITE);
  assign full       = (count == CW'(DEPTH));

  // Rank active requests in source order; lower index claims the older slot
  always_comb begin
    ack      = '0;
    push_en  = '0;
    push_idx = '0;
    pushes   = '0;
    for (int s = 0; s < SRC; s++) begin
      if (!req_[s] && reset_ && !full) begin
        if (ZERO_REG && (req_addr[s] == '0)) begin
          ack[s] = 1'b1;
        end else if (pushes < free_slots) begin
          ack[s]      = 1'b1;
          push_en[s]  = 1'b1;
          push_idx[s] = tail + PW'(pushes);
          pushes      = pushes + CW'(1);
        end
      end
    end
  end

  // Present the oldest min(count, WRITE) entries on the write ports
  always_comb begin
    we_    = '1;
    waddr  = '0;
    wdata  = '0;
    rd_idx = '0;
    for (int j = 0; j < WRITE; j++) begin
      if (CW'(j) < pops) begin
        rd_idx   = head + PW'(j);
        we_[j]   = 1'b0;
        waddr[j] = e_addr[rd_idx];
        wdata[j] = e_data[rd_idx];
      end
    end
  end

  // Bypass lookup: walk oldest to youngest so the last match wins
  always_comb begin
    qhit   = 1'b0;
    qdata  = '0;
    lk_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head + PW'(i);
      if ((CW'(i) < count) && (e_addr[lk_idx] == qaddr)) begin
        qhit  = 1'b1;
        qdata = e_data[lk_idx];
      end
    end
  end

  // Pointer and occupancy update; reset overrides both push and pop
  always_ff @(posedge clk) begin
    if (!reset_) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pops);
      tail  <= tail + PW'(pushes);
      count <= count + pushes - pops;
    end
  end

  // Entry storage; push_en is already blocked while reset is asserted
  always_ff @(posedge clk) begin
    for (int s = 0; s < SRC; s++) begin
      if (push_en[s]) begin
        e_addr[push_idx[s]] <= req_addr[s];
        e_data[push_idx[s]] <= req_data[s];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: a vector table for the basic
// single/dual write and lookup cases, a queue model for the streaming,
// wrap and mid-queue reset sequences, and a second small instance
// (DEPTH=2, zero register discarded) for the full and address-0 cases.
module tb_regfile_wb_queue;

  logic              clk = 1'b0;
  logic              reset_;
  logic [1:0]        req_;
  logic [1:0][3:0]   req_addr;
  logic [1:0][31:0]  req_data;
  logic [1:0]        ack;
  logic [0:0][3:0]   waddr;
  logic [0:0]        we_;
  logic [0:0][31:0]  wdata;
  logic [3:0]        qaddr;
  logic              qhit;
  logic [31:0]       qdata;
  logic [3:0]        count;
  logic              full;

  logic [1:0]        zreq_;
  logic [1:0][3:0]   zreq_addr;
  logic [1:0][31:0]  zreq_data;
  logic [1:0]        zack;
  logic [0:0][3:0]   zwaddr;
  logic [0:0]        zwe_;
  logic [0:0][31:0]  zwdata;
  logic [3:0]        zqaddr;
  logic              zqhit;
  logic [31:0]       zqdata;
  logic [1:0]        zcount;
  logic              zfull;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DATA(32), .ADDR(4), .SRC(2), .WRITE(1), .DEPTH(8), .ZERO_REG(1'b0)) dut (
    .clk(clk), .reset_(reset_), .req_(req_), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .waddr(waddr), .we_(we_), .wdata(wdata), .qaddr(qaddr), .qhit(qhit),
    .qdata(qdata), .count(count), .full(full)
  );

  regfile_wb_queue #(.DATA(32), .ADDR(4), .SRC(2), .WRITE(1), .DEPTH(2), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .reset_(reset_), .req_(zreq_), .req_addr(zreq_addr), .req_data(zreq_data),
    .ack(zack), .waddr(zwaddr), .we_(zwe_), .wdata(zwdata), .qaddr(zqaddr), .qhit(zqhit),
    .qdata(zqdata), .count(zcount), .full(zfull)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rq;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic [3:0]  qa;
    logic [1:0]  e_ack;
    logic        e_we;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;
    logic [3:0]  e_cnt;
    logic        e_qhit;
    logic [31:0] e_qd;
    logic        e_full;
  } vec_t;

  vec_t vt[13];
  logic [35:0] mq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle on the main instance checked against the queue model
  task automatic mcyc(input string nm, input logic [1:0] rq, input logic [3:0] a0,
                      input logic [31:0] d0, input logic [3:0] a1, input logic [31:0] d1,
                      input logic [3:0] qa);
    int f;
    int k;
    logic [1:0]  eack;
    logic        hit;
    logic [31:0] qd;
    @(posedge clk); #1;
    req_ = rq; req_addr[0] = a0; req_data[0] = d0; req_addr[1] = a1; req_data[1] = d1;
    qaddr = qa;
    @(negedge clk);
    f = 8 - mq.size();
    k = 0;
    eack = 2'b00;
    for (int s = 0; s < 2; s++) begin
      if (!rq[s]) begin
        k++;
        if (k <= f) eack[s] = 1'b1;
      end
    end
    hit = 1'b0;
    qd = '0;
    foreach (mq[i]) begin
      if (mq[i][35:32] == qa) begin
        hit = 1'b1;
        qd = mq[i][31:0];
      end
    end
    check({nm, "_ack"}, 64'(ack), 64'(eack));
    check({nm, "_count"}, 64'(count), 64'(mq.size()));
    check({nm, "_full"}, 64'(full), 64'(mq.size() == 8));
    check({nm, "_qhit"}, 64'(qhit), 64'(hit));
    check({nm, "_qdata"}, 64'(qdata), 64'(qd));
    if (mq.size() > 0) begin
      check({nm, "_we"}, 64'(we_), 64'd0);
      check({nm, "_waddr"}, 64'(waddr[0]), 64'(mq[0][35:32]));
      check({nm, "_wdata"}, 64'(wdata[0]), 64'(mq[0][31:0]));
      void'(mq.pop_front());
    end else begin
      check({nm, "_we"}, 64'(we_), 64'd1);
    end
    if (eack[0]) mq.push_back({a0, d0});
    if (eack[1]) mq.push_back({a1, d1});
  endtask

  task automatic zdrive(input logic [1:0] rq, input logic [3:0] a0, input logic [31:0] d0,
                        input logic [3:0] a1, input logic [31:0] d1, input logic [3:0] qa);
    @(posedge clk); #1;
    zreq_ = rq; zreq_addr[0] = a0; zreq_data[0] = d0; zreq_addr[1] = a1; zreq_data[1] = d1;
    zqaddr = qa;
    @(negedge clk);
  endtask

  task automatic zcheck(input string nm, input logic [1:0] eack, input logic ewe,
                        input logic [3:0] ewa, input logic [31:0] ewd, input logic [1:0] ecnt,
                        input logic efull, input logic eqhit);
    check({nm, "_ack"}, 64'(zack), 64'(eack));
    check({nm, "_we"}, 64'(zwe_), 64'(ewe));
    check({nm, "_waddr"}, 64'(zwaddr[0]), 64'(ewa));
    check({nm, "_wdata"}, 64'(zwdata[0]), 64'(ewd));
    check({nm, "_count"}, 64'(zcount), 64'(ecnt));
    check({nm, "_full"}, 64'(zfull), 64'(efull));
    check({nm, "_qhit"}, 64'(zqhit), 64'(eqhit));
  endtask

  initial begin
    //            rst  rq     a0  d0            a1  d1     qa   ack    we  wa  wd            cnt qhit qd            full
    vt[0]  = '{1'b0, 2'b00, 4'd1, 32'h11,       4'd2, 32'h22, 4'd1, 2'b00, 1'b1, 4'd0, 32'h0,        4'd0, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 2'b00, 4'd1, 32'h11,       4'd2, 32'h22, 4'd1, 2'b00, 1'b1, 4'd0, 32'h0,        4'd0, 1'b0, 32'h0,        1'b0};
    vt[2]  = '{1'b1, 2'b10, 4'd3, 32'hA5A5_0001, 4'd0, 32'h0,  4'd3, 2'b01, 1'b1, 4'd0, 32'h0,        4'd0, 1'b0, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 2'b11, 4'd0, 32'h0,        4'd0, 32'h0,  4'd3, 2'b00, 1'b0, 4'd3, 32'hA5A5_0001, 4'd1, 1'b1, 32'hA5A5_0001, 1'b0};
    vt[4]  = '{1'b1, 2'b11, 4'd0, 32'h0,        4'd0, 32'h0,  4'd3, 2'b00, 1'b1, 4'd0, 32'h0,        4'd0, 1'b0, 32'h0,        1'b0};
    vt[5]  = '{1'b1, 2'b00, 4'd5, 32'h1,        4'd5, 32'h2,  4'd5, 2'b11, 1'b1, 4'd0, 32'h0,        4'd0, 1'b0, 32'h0,        1'b0};
    vt[6]  = '{1'b1, 2'b11, 4'd0, 32'h0,        4'd0, 32'h0,  4'd5, 2'b00, 1'b0, 4'd5, 32'h1,        4'd2, 1'b1, 32'h2,        1'b0};
    vt[7]  = '{1'b1, 2'b11, 4'd0, 32'h0,        4'd0, 32'h0,  4'd5, 2'b00, 1'b0, 4'd5, 32'h2,        4'd1, 1'b1, 32'h2,        1'b0};
    vt[8]  = '{1'b1, 2'b11, 4'd0, 32'h0,        4'd0, 32'h0,  4'd5, 2'b00, 1'b1, 4'd0, 32'h0,        4'd0, 1'b0, 32'h0,        1'b0};
    vt[9]  = '{1'b1, 2'b00, 4'd9, 32'h90,       4'd4, 32'h40, 4'd9, 2'b11, 1'b1, 4'd0, 32'h0,        4'd0, 1'b0, 32'h0,        1'b0};
    vt[10] = '{1'b1, 2'b11, 4'd0, 32'h0,        4'd0, 32'h0,  4'd4, 2'b00, 1'b0, 4'd9, 32'h90,       4'd2, 1'b1, 32'h40,       1'b0};
    vt[11] = '{1'b1, 2'b11, 4'd0, 32'h0,        4'd0, 32'h0,  4'd9, 2'b00, 1'b0, 4'd4, 32'h40,       4'd1, 1'b0, 32'h0,        1'b0};
    vt[12] = '{1'b1, 2'b11, 4'd0, 32'h0,        4'd0, 32'h0,  4'd9, 2'b00, 1'b1, 4'd0, 32'h0,        4'd0, 1'b0, 32'h0,        1'b0};

    reset_ = 1'b0;
    req_ = 2'b11; req_addr = '0; req_data = '0; qaddr = '0;
    zreq_ = 2'b11; zreq_addr = '0; zreq_data = '0; zqaddr = '0;

    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      reset_ = vt[i].rst;
      req_ = vt[i].rq;
      req_addr[0] = vt[i].a0; req_data[0] = vt[i].d0;
      req_addr[1] = vt[i].a1; req_data[1] = vt[i].d1;
      qaddr = vt[i].qa;
      @(negedge clk);
      check($sformatf("v%0d_ack", i), 64'(ack), 64'(vt[i].e_ack));
      check($sformatf("v%0d_we", i), 64'(we_), 64'(vt[i].e_we));
      check($sformatf("v%0d_waddr", i), 64'(waddr[0]), 64'(vt[i].e_wa));
      check($sformatf("v%0d_wdata", i), 64'(wdata[0]), 64'(vt[i].e_wd));
      check($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
      check($sformatf("v%0d_qhit", i), 64'(qhit), 64'(vt[i].e_qhit));
      check($sformatf("v%0d_qdata", i), 64'(qdata), 64'(vt[i].e_qd));
      check($sformatf("v%0d_full", i), 64'(full), 64'(vt[i].e_full));
    end

    // Zero-register discard and full back-pressure on the small instance
    zdrive(2'b00, 4'd0, 32'hDEAD, 4'd7, 32'h77, 4'd7);
    zcheck("z_zero_push", 2'b11, 1'b1, 4'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    zdrive(2'b11, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0);
    zcheck("z_zero_drain", 2'b00, 1'b0, 4'd7, 32'h77, 2'd1, 1'b0, 1'b0);
    zdrive(2'b11, 4'd0, 32'h0, 4'd0, 32'h0, 4'd7);
    zcheck("z_zero_empty", 2'b00, 1'b1, 4'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    zdrive(2'b00, 4'd1, 32'h101, 4'd2, 32'h202, 4'd2);
    zcheck("z_fill", 2'b11, 1'b1, 4'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    zdrive(2'b00, 4'd3, 32'h303, 4'd4, 32'h404, 4'd2);
    zcheck("z_full", 2'b00, 1'b0, 4'd1, 32'h101, 2'd2, 1'b1, 1'b1);
    zdrive(2'b00, 4'd3, 32'h303, 4'd4, 32'h404, 4'd3);
    zcheck("z_resume", 2'b01, 1'b0, 4'd2, 32'h202, 2'd1, 1'b0, 1'b0);
    zdrive(2'b01, 4'd0, 32'h0, 4'd4, 32'h404, 4'd3);
    zcheck("z_retry", 2'b10, 1'b0, 4'd3, 32'h303, 2'd1, 1'b0, 1'b1);
    zdrive(2'b11, 4'd0, 32'h0, 4'd0, 32'h0, 4'd4);
    zcheck("z_last", 2'b00, 1'b0, 4'd4, 32'h404, 2'd1, 1'b0, 1'b1);
    zdrive(2'b11, 4'd0, 32'h0, 4'd0, 32'h0, 4'd4);
    zcheck("z_done", 2'b00, 1'b1, 4'd0, 32'h0, 2'd0, 1'b0, 1'b0);

    // Two pushes per cycle against one drain port: occupancy saturates at 7
    for (int i = 0; i < 10; i++)
      mcyc($sformatf("s%0d", i), 2'b00, 4'(2 * i), 32'h1000 + 32'(i),
           4'(2 * i + 1), 32'h2000 + 32'(i), 4'(i));
    mcyc("s_dr0", 2'b11, 4'd0, 32'h0, 4'd0, 32'h0, 4'd3);
    mcyc("s_dr1", 2'b11, 4'd0, 32'h0, 4'd0, 32'h0, 4'd3);
    check("s_depth5", 64'(mq.size()), 64'd5);

    // Reset with entries queued: requests blocked, queue emptied
    @(posedge clk); #1;
    reset_ = 1'b0; req_ = 2'b00; req_addr[0] = 4'd6; req_addr[1] = 4'd7;
    @(negedge clk);
    check("r_ack_in_reset", 64'(ack), 64'd0);
    @(posedge clk); #1;
    reset_ = 1'b1; req_ = 2'b11;
    @(negedge clk);
    check("r_count", 64'(count), 64'd0);
    check("r_we", 64'(we_), 64'd1);
    check("r_qhit", 64'(qhit), 64'd0);
    mq.delete();
    mcyc("r_idle", 2'b11, 4'd0, 32'h0, 4'd0, 32'h0, 4'd2);

    // Stream 20 writes one per cycle so both pointers wrap
    for (int i = 0; i < 20; i++)
      mcyc($sformatf("w%0d", i), 2'b10, 4'(i), 32'hC000 + 32'(i), 4'd0, 32'h0, 4'(i));
    for (int i = 0; i < 3; i++)
      mcyc($sformatf("w_dr%0d", i), 2'b11, 4'd0, 32'h0, 4'd0, 32'h0, 4'd3);
    check("w_final_count", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
